// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, fetch FSM states and FIFO entry layout for the instruction fetch buffer
package fetch_pkg;
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of fetched {pc, instr} entries with synchronous flush
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type T = entry_t
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  T                       wdata,
    output T                       head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    T mem [DEPTH];
    logic [PW-1:0] rp, wp;
    assign head = mem[rp];
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else if (flush) begin
            rp <= '0;
            wp <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= wdata;
                wp <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: PC-address consumer issuing single-outstanding memory reads into a decode FIFO
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_W-1:0]      addrA,
    input  logic                   addr_valid,
    output logic                   addr_ready,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    input  logic                   flush,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [DATA_W-1:0]      instr,
    output logic [ADDR_W-1:0]      instr_pc,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } ent_t;
    state_t state;
    ent_t head;
    logic in_flight, fire, push, pop;
    // The outstanding request holds a FIFO slot, so credit counts it alongside queued entries
    assign in_flight = state != IDLE;
    assign addr_ready = !flush && (state == IDLE || (state == REQ && mem_ack))
                        && (({1'b0, count} + CW'(in_flight)) < CW'(DEPTH));
    assign fire = addr_valid && addr_ready;
    assign push = state == REQ && mem_ack && !flush;
    assign pop = instr_valid && instr_ready;
    assign instr_valid = count != '0;
    assign instr = head.instr;
    assign instr_pc = head.pc;
    fetch_fifo #(.DEPTH(DEPTH), .T(ent_t)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .flush(flush),
        .wdata('{pc: mem_addr, instr: mem_rdata}),
        .head(head),
        .count(count)
    );
    // A flushed request stays asserted until acked; only its data is discarded
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_addr <= '0;
        end else if (fire) begin
            state <= REQ;
            mem_req <= 1'b1;
            mem_addr <= addrA;
        end else if (in_flight && mem_ack) begin
            state <= IDLE;
            mem_req <= 1'b0;
        end else if (flush && state == REQ) begin
            state <= DROP;
        end
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed self-checking bench for instr_fetch_buffer
module tb_instr_fetch_buffer;
    import fetch_pkg::*;
    logic        clock = 0, reset = 1;
    logic [31:0] addrA = 0, mem_addr, mem_rdata, instr, instr_pc;
    logic        addr_valid = 0, addr_ready, mem_req, mem_ack, flush = 0;
    logic        instr_valid, instr_ready = 0, auto_ack = 0, man_ack = 0;
    logic [2:0]  count;
    int checks = 0, failures = 0;
    always #5 clock = ~clock;
    assign mem_ack = auto_ack ? mem_req : man_ack;
    assign mem_rdata = 32'hA000_0000 + mem_addr;
    instr_fetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .addrA(addrA), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .count(count)
    );
    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask
    task automatic nxt;
        @(posedge clock);
        #1;
    endtask
    initial begin
        #1;
        chk("rst_count", count, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc", instr_pc, 0);
        nxt(); nxt();
        reset = 0;
        // 1: zero-wait stream
        nxt();
        auto_ack = 1; instr_ready = 1;
        for (int i = 0; i < 6; i++) begin
            addr_valid = i < 4; addrA = i;
            #1;
            if (i < 4) chk("t1_ready", addr_ready, 1);
            chk("t1_valid", instr_valid, i >= 2);
            if (i >= 2) begin
                chk("t1_pc", instr_pc, i - 2);
                chk("t1_instr", instr, 32'hA000_0000 + i - 2);
            end
            nxt();
        end
        #1;
        chk("t1_empty", instr_valid, 0);
        chk("t1_idle", 64'(dut.state), 64'(IDLE));
        // 2: backpressure until full, then drain
        instr_ready = 0;
        for (int c = 0; c < 6; c++) begin
            addr_valid = 1; addrA = c < 4 ? c : 4;
            #1;
            chk("t2_ready", addr_ready, c < 4);
            nxt();
        end
        chk("t2_count", count, 4);
        chk("t2_req", mem_req, 0);
        instr_ready = 1; addrA = 4;
        #1;
        chk("t2_d0_ready", addr_ready, 0);
        chk("t2_d0_pc", instr_pc, 0);
        nxt();
        #1;
        chk("t2_d1_ready", addr_ready, 1);
        chk("t2_d1_pc", instr_pc, 1);
        nxt();
        addrA = 5;
        #1;
        chk("t2_d2_ready", addr_ready, 1);
        chk("t2_d2_addr", mem_addr, 4);
        chk("t2_d2_pc", instr_pc, 2);
        nxt();
        addr_valid = 0;
        #1;
        chk("t2_d3_addr", mem_addr, 5);
        chk("t2_d3_pc", instr_pc, 3);
        chk("t2_d3_count", count, 2);
        nxt();
        #1;
        chk("t2_d4_pc", instr_pc, 4);
        chk("t2_d4_count", count, 2);
        nxt();
        #1;
        chk("t2_d5_pc", instr_pc, 5);
        chk("t2_d5_instr", instr, 32'hA000_0005);
        nxt();
        #1;
        chk("t2_d6_empty", instr_valid, 0);
        // 3: three-cycle ack delay
        auto_ack = 0; instr_ready = 0;
        addr_valid = 1; addrA = 32'h10;
        #1;
        chk("t3_accept", addr_ready, 1);
        nxt();
        addrA = 32'h11;
        for (int w = 0; w < 3; w++) begin
            #1;
            chk("t3_wait_ready", addr_ready, 0);
            chk("t3_wait_req", mem_req, 1);
            chk("t3_wait_addr", mem_addr, 32'h10);
            nxt();
        end
        addr_valid = 0; man_ack = 1;
        #1;
        chk("t3_ack_req", mem_req, 1);
        chk("t3_ack_addr", mem_addr, 32'h10);
        nxt();
        man_ack = 0;
        #1;
        chk("t3_count", count, 1);
        chk("t3_pc", instr_pc, 32'h10);
        chk("t3_instr", instr, 32'hA000_0010);
        chk("t3_req_low", mem_req, 0);
        nxt();
        #1;
        chk("t3_one_push", count, 1);
        instr_ready = 1;
        nxt();
        #1;
        chk("t3_drained", count, 0);
        // 4: flush while a request is outstanding
        addr_valid = 1; addrA = 32'h20;
        nxt();
        addr_valid = 0;
        nxt();
        flush = 1;
        #1;
        chk("t4_flush_ready", addr_ready, 0);
        nxt();
        flush = 0; addr_valid = 1; addrA = 32'h40;
        #1;
        chk("t4_drop", 64'(dut.state), 64'(DROP));
        chk("t4_drop_req", mem_req, 1);
        chk("t4_drop_addr", mem_addr, 32'h20);
        chk("t4_drop_ready", addr_ready, 0);
        nxt();
        man_ack = 1;
        #1;
        chk("t4_ack_ready", addr_ready, 0);
        nxt();
        man_ack = 0;
        #1;
        chk("t4_idle", 64'(dut.state), 64'(IDLE));
        chk("t4_count", count, 0);
        chk("t4_valid", instr_valid, 0);
        chk("t4_accept40", addr_ready, 1);
        nxt();
        addr_valid = 0; man_ack = 1;
        nxt();
        man_ack = 0;
        #1;
        chk("t4_pc40", instr_pc, 32'h40);
        chk("t4_instr40", instr, 32'hA000_0040);
        chk("t4_count1", count, 1);
        nxt();
        // 5: flush coincident with ack, two entries queued
        instr_ready = 0; auto_ack = 1;
        addr_valid = 1; addrA = 32'h50;
        nxt();
        addrA = 32'h51;
        nxt();
        addr_valid = 0;
        nxt();
        auto_ack = 0;
        #1;
        chk("t5_count2", count, 2);
        addr_valid = 1; addrA = 32'h52;
        nxt();
        addr_valid = 0; man_ack = 1; flush = 1;
        #1;
        chk("t5_flush_ready", addr_ready, 0);
        nxt();
        man_ack = 0; flush = 0;
        #1;
        chk("t5_count", count, 0);
        chk("t5_valid", instr_valid, 0);
        chk("t5_idle", 64'(dut.state), 64'(IDLE));
        chk("t5_req", mem_req, 0);
        nxt();
        #1;
        chk("t5_discarded", count, 0);
        // 6: asynchronous reset mid-request
        auto_ack = 1;
        addr_valid = 1; addrA = 32'h60;
        nxt();
        addrA = 32'h61;
        nxt();
        addrA = 32'h62;
        nxt();
        addrA = 32'h63;
        nxt();
        auto_ack = 0; addr_valid = 0;
        #1;
        chk("t6_count3", count, 3);
        chk("t6_req", 64'(dut.state), 64'(REQ));
        #1;
        reset = 1;
        #1;
        chk("t6_async_req", mem_req, 0);
        chk("t6_async_count", count, 0);
        chk("t6_async_valid", instr_valid, 0);
        nxt();
        reset = 0;
        auto_ack = 1; instr_ready = 1;
        addr_valid = 1; addrA = 32'h80;
        #1;
        chk("t6_accept", addr_ready, 1);
        nxt();
        addr_valid = 0;
        #1;
        chk("t6_mem_addr", mem_addr, 32'h80);
        nxt();
        #1;
        chk("t6_pc", instr_pc, 32'h80);
        chk("t6_instr", instr, 32'hA000_0080);
        nxt();
        #1;
        chk("t6_empty", instr_valid, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
- Consumer side of the program-counter address stream.
- Accepts instruction addresses from the PC through a valid/ready handshake and issues single-outstanding reads to instruction memory over a req/ack interface.
- Queues each returned instruction with its PC in a DEPTH-entry FIFO and presents it to decode with valid/ready.
- Drives address backpressure to the PC and supports flush on branch/jump redirect, including dropping an in-flight response.

Parameters:
ADDR_W, 32, width of instruction address / PC
DATA_W, 32, width of instruction word
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
addrA  in  ADDR_W  instruction address from program counter
addr_valid  in  1  addrA is valid
addr_ready  out  1  address accepted this cycle; PC must hold addrA while low
mem_req  out  1  read request to instruction memory (registered)
mem_addr  out  ADDR_W  read address (registered, stable while mem_req high)
mem_ack  in  1  read data valid; legal in any cycle mem_req is high, including the first
mem_rdata  in  DATA_W  instruction word, valid with mem_ack
flush  in  1  redirect: discard queued and in-flight instructions
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode consumes head
instr  out  DATA_W  head instruction
instr_pc  out  ADDR_W  head PC
count  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async): state=IDLE; count=0; rd/wr pointers=0; mem_req=0; mem_addr=0; storage=0, so instr=0 and instr_pc=0; instr_valid=0.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response will be kept.
  - DROP: request outstanding, response will be discarded.
- in_flight = (state != IDLE).
- Accept condition (registered values only, no pop bypass): addr_ready = !flush && (state==IDLE || (state==REQ && mem_ack)) && (count + in_flight < DEPTH).
- Address handshake: transfer on addr_valid && addr_ready. Next cycle: mem_addr=addrA, mem_req=1, state=REQ.
- REQ, mem_ack=0: hold mem_req and mem_addr unchanged.
- REQ, mem_ack=1:
  - Push {mem_rdata, mem_addr} to the FIFO.
  - If a new address is accepted the same cycle, remain in REQ with the new mem_addr (back-to-back).
  - Otherwise go to IDLE with mem_req=0.
- Zero-wait memory gives 1 instruction/cycle steady-state throughput.
- Latency: address accepted cycle N -> mem_req high cycle N+1; ack at cycle M -> entry visible at M+1 (instr_valid=1 if the FIFO was empty).
- FIFO:
  - instr_valid = (count != 0); instr and instr_pc read the head entry combinationally from registered storage.
  - Pop on instr_valid && instr_ready.
  - Push and pop in the same cycle leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Overflow is impossible by credit; underflow is impossible by the instr_valid gate.
- flush (highest priority), next cycle:
  - count=0, pointers=0, instr_valid=0.
  - Any push or pop that cycle is ignored.
  - addr_ready=0 in the flush cycle.
  - REQ without ack: go to DROP, keep mem_req/mem_addr asserted (a request is never retracted).
  - REQ with ack: data discarded, go to IDLE.
  - IDLE: stay in IDLE.
  - DROP: stay in DROP.
- DROP: addr_ready=0; on mem_ack, discard data and go to IDLE with mem_req=0; the next address is accepted from IDLE.
- mem_ack while state==IDLE is ignored.
- Reset mid-operation: immediate return to reset values regardless of state. The memory side must tolerate mem_req dropping.

Decomposition:
- Shared package fetch_pkg:
  - ADDR_W/DATA_W defaults.
  - State enum {IDLE, REQ, DROP}.
  - Entry struct {pc, instr}.
- Sub-module fetch_fifo (DEPTH entries of the entry struct; push, pop, flush, count, head outputs).
- Top level holds the FSM, accept/credit logic and memory interface registers.

Test Plan:
1. Zero-wait stream:
   - Stimulus: addrA 0,1,2,3 presented back-to-back; mem_ack high whenever mem_req is high, mem_rdata=0xA000_0000+addr; instr_ready=1.
   - Required: addr_ready high 4 consecutive cycles; instr_valid high 4 consecutive cycles starting 2 cycles after the first accept; instr_pc 0..3; instr 0xA000_0000..0xA000_0003.
2. Backpressure full:
   - Stimulus: DEPTH=4, instr_ready=0, 6 addresses offered, zero-wait memory.
   - Required: exactly 4 accepted, then addr_ready=0, count=4, mem_req=0.
   - Then instr_ready=1: pops resume and remaining addresses 4,5 are accepted in order.
3. Variable latency:
   - Stimulus: mem_ack delayed 3 cycles on addr 0x10.
   - Required: mem_req and mem_addr=0x10 stable for 4 cycles; addr_ready=0 while waiting; exactly one push.
4. Flush in flight:
   - Stimulus: flush 1 cycle after addr 0x20 is issued; ack 2 cycles later; addr 0x40 then offered.
   - Required: state DROP; 0x20 data never appears; count=0; next instr_pc=0x40.
5. Flush coincident with ack:
   - Stimulus: flush and mem_ack in the same cycle with 2 entries queued.
   - Required: next cycle count=0, instr_valid=0, state IDLE, acked data discarded.
6. Async reset:
   - Stimulus: reset asserted mid-REQ with count=3, between clock edges.
   - Required: mem_req=0, count=0, instr_valid=0 immediately, without waiting for a clock edge; normal fetch from a new address after release.
